regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Responder side of the register-file access protocol used by execution units (branch, data-processing, load/store): per-unit read_en/read_reg and write_en/write_reg/write_value pulse requests.
- Queues one request per client, arbitrates round-robin, and drives the single register_file port.
- Returns write acks and read data with a valid pulse, so units no longer need exclusive, hand-timed access to register_file.

Parameters:
- NUM_CLIENTS, 2, number of requesting units (1..4).
- REG_W, 4, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_read_en  in  NUM_CLIENTS  per-client read request pulse.
- req_read_reg  in  NUM_CLIENTS*REG_W  per-client read index; client i uses slice [i*REG_W +: REG_W].
- req_write_en  in  NUM_CLIENTS  per-client write request pulse.
- req_write_reg  in  NUM_CLIENTS*REG_W  per-client write index.
- req_write_value  in  NUM_CLIENTS*DATA_W  per-client write data.
- busy  out  NUM_CLIENTS  client slot occupied.
- rd_valid  out  NUM_CLIENTS  one-cycle read-data-valid pulse.
- rd_data  out  DATA_W  read data, shared bus; valid only with rd_valid.
- wr_ack  out  NUM_CLIENTS  one-cycle write-completed pulse.
- req_err  out  NUM_CLIENTS  one-cycle pulse: request dropped.
- rf_read_en  out  1  to register_file.read_en.
- rf_read_reg  out  REG_W  to register_file.read_reg.
- rf_read_value  in  DATA_W  from register_file.read_value.
- rf_write_en  out  1  to register_file.write_en.
- rf_write_reg  out  REG_W  to register_file.write_reg.
- rf_write_value  out  DATA_W  to register_file.write_value.

Behaviour:
- Reset (async, immediate): all outputs 0; slots empty; FSM = IDLE; round-robin pointer = 0.
- Slot capture:
  - On a clk edge with req_*_en=1 and slot i empty: latch {is_write, reg, value}.
  - busy[i] rises the next cycle and stays high until the cycle of wr_ack[i] or rd_valid[i].
- Request while busy[i]=1: dropped, req_err[i]=1 the next cycle, slot unchanged.
- req_read_en and req_write_en both high from one client in the same cycle: the write is captured, the read is dropped, req_err pulses.
- Client must not reissue in the completion cycle; a request in that cycle is treated as busy and dropped with req_err.
- FSM states IDLE, WR, RD_ISSUE, RD_WAIT, RD_CAP:
  - IDLE: select the first occupied slot starting at pointer, wrapping modulo NUM_CLIENTS. Write -> WR; read -> RD_ISSUE. No occupied slot -> stay in IDLE.
  - WR: rf_write_en=1 for exactly one cycle with the slot's reg/value. Next cycle: wr_ack[i]=1, slot cleared, pointer=i+1 mod N, -> IDLE.
  - RD_ISSUE: rf_read_en=1 for one cycle -> RD_WAIT.
  - RD_WAIT: rf_read_en=0 (register_file output settles) -> RD_CAP.
  - RD_CAP: rd_data<=rf_read_value. Next cycle: rd_valid[i]=1, slot cleared, pointer advances, -> IDLE.
- rd_data holds its value until the next capture.
- rf_*_reg/value are driven from the granted slot while the corresponding enable is high, and hold their last value otherwise.
- Latency from request edge with arbiter idle: wr_ack after 3 cycles, rd_valid after 5 cycles. Each pending slot ahead in round-robin order adds its own service time.
- Write followed by read of the same register from a different client, write granted first: the read returns the new value.
- Any request to register 15 is passed through unchanged; PC semantics stay with register_file.
- No combinational path from req_* to rf_* or to any response output.

Decomposition:
- Shared package: FSM state encoding constants; REG_PC=15 and REG_LR=14 index constants; slot record layout widths.
- One sub-module, rr_pointer_select: given occupied mask and pointer, returns grant index and any-valid.
- Slots and FSM stay in the top module.

Test Plan:
- Single write: client0 writes r3=0xDEADBEEF -> rf_write_en pulses once with reg 3, value DEADBEEF; wr_ack[0] 3 cycles after request; busy[0] low after it.
- Single read: preload r15=0x1000, client1 reads r15 -> rd_valid[1] with rd_data=0x00001000, rf_read_en high exactly one cycle.
- Collision: same edge, client0 writes r14=0x2004 and client1 reads r14 -> client0 write served first (pointer 0), then client1 gets rd_data=0x00002004.
- Fairness: both clients continuously re-request writes for 8 transactions -> grants alternate 0,1,0,1; no client starved.
- Overrun and illegal: client0 issues a second request while busy, and separately read+write in one cycle -> req_err[0] pulses in both cases; the original slot completes normally.
- Reset mid-operation: assert rst during RD_WAIT -> rf_read_en/rf_write_en, busy, rd_valid low immediately; after release, a new read of r15 completes with the correct value.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared encodings for the register-file port arbiter: FSM states,
// architectural register indices and the per-client slot record layout.
package regfile_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_CAP   = 3'd4
  } arb_state_t;

  localparam int REG_PC = 15;
  localparam int REG_LR = 14;

  // Slot record is {is_write, reg, value}, value in the low bits.
  localparam int SLOT_KIND_W = 1;

  function automatic int slot_w(input int reg_w, input int data_w);
    return SLOT_KIND_W + reg_w + data_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pointer_select.sv
// Round-robin pick: first set bit of occupied at or after ptr, wrapping.
module rr_pointer_select #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     occupied,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  logic             hit_hi;
  logic [IDX_W-1:0] sel_hi;
  logic [IDX_W-1:0] sel_lo;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_hi = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (occupied[j]) begin
        sel_lo = IDX_W'(j);
        if (IDX_W'(j) >= ptr) begin
          hit_hi = 1'b1;
          sel_hi = IDX_W'(j);
        end
      end
    end
    grant     = hit_hi ? sel_hi : sel_lo;
    any_valid = |occupied;
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Queues one register-file request per execution unit, arbitrates them
// round-robin onto the single register_file port and returns acks/read data.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int REG_W       = 4,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req_read_en,
  input  logic [NUM_CLIENTS*REG_W-1:0]  req_read_reg,
  input  logic [NUM_CLIENTS-1:0]        req_write_en,
  input  logic [NUM_CLIENTS*REG_W-1:0]  req_write_reg,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_write_value,
  output logic [NUM_CLIENTS-1:0]        busy,
  output logic [NUM_CLIENTS-1:0]        rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic [NUM_CLIENTS-1:0]        wr_ack,
  output logic [NUM_CLIENTS-1:0]        req_err,
  output logic                          rf_read_en,
  output logic [REG_W-1:0]              rf_read_reg,
  input  logic [DATA_W-1:0]             rf_read_value,
  output logic                          rf_write_en,
  output logic [REG_W-1:0]              rf_write_reg,
  output logic [DATA_W-1:0]             rf_write_value
);

  localparam int IDX_W  = idx_w(NUM_CLIENTS);
  localparam int SLOT_W = slot_w(REG_W, DATA_W);

  logic [NUM_CLIENTS-1:0]             occ;
  logic [NUM_CLIENTS-1:0][SLOT_W-1:0] slot_q;
  logic [NUM_CLIENTS-1:0]             done;
  logic [NUM_CLIENTS-1:0]             eligible;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, cur, gnt_idx, cur_inc;
  logic             gnt_any;
  logic [SLOT_W-1:0] gnt_slot;
  logic             gnt_is_wr;

  // A slot stays occupied through its completion cycle; mask it so the
  // arbiter does not re-grant it while the ack/valid pulse is out.
  assign done     = wr_ack | rd_valid;
  assign eligible = occ & ~done;
  assign busy     = occ;

  assign gnt_slot  = slot_q[gnt_idx];
  assign gnt_is_wr = gnt_slot[SLOT_W-1];
  assign cur_inc   = (cur == IDX_W'(NUM_CLIENTS - 1)) ? '0 : cur + 1'b1;

  rr_pointer_select #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_rr_sel (
    .occupied  (eligible),
    .ptr       (ptr),
    .grant     (gnt_idx),
    .any_valid (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ     <= '0;
      slot_q  <= '0;
      req_err <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        req_err[i] <= 1'b0;
        if (done[i]) occ[i] <= 1'b0;
        if (req_write_en[i] || req_read_en[i]) begin
          if (occ[i]) begin
            req_err[i] <= 1'b1;
          end else begin
            occ[i]     <= 1'b1;
            // Write wins a simultaneous read; the read is reported dropped.
            slot_q[i]  <= req_write_en[i]
                ? {1'b1, req_write_reg[i*REG_W +: REG_W], req_write_value[i*DATA_W +: DATA_W]}
                : {1'b0, req_read_reg[i*REG_W +: REG_W], {DATA_W{1'b0}}};
            req_err[i] <= req_write_en[i] && req_read_en[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (gnt_any) state_nxt = gnt_is_wr ? ST_WR : ST_RD_ISSUE;
      ST_WR:       state_nxt = ST_IDLE;
      ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  state_nxt = ST_RD_CAP;
      ST_RD_CAP:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Port drives and responses are registered so nothing combinational
  // reaches them from the request inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      cur            <= '0;
      wr_ack         <= '0;
      rd_valid       <= '0;
      rd_data        <= '0;
      rf_read_en     <= 1'b0;
      rf_read_reg    <= '0;
      rf_write_en    <= 1'b0;
      rf_write_reg   <= '0;
      rf_write_value <= '0;
    end else begin
      wr_ack      <= '0;
      rd_valid    <= '0;
      rf_read_en  <= 1'b0;
      rf_write_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            cur <= gnt_idx;
            if (gnt_is_wr) begin
              rf_write_en    <= 1'b1;
              rf_write_reg   <= gnt_slot[DATA_W +: REG_W];
              rf_write_value <= gnt_slot[DATA_W-1:0];
            end else begin
              rf_read_en  <= 1'b1;
              rf_read_reg <= gnt_slot[DATA_W +: REG_W];
            end
          end
        end
        ST_WR: begin
          wr_ack[cur] <= 1'b1;
          ptr         <= cur_inc;
        end
        ST_RD_CAP: begin
          rd_data       <= rf_read_value;
          rd_valid[cur] <= 1'b1;
          ptr           <= cur_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file.
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int RW = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_read_en, req_write_en;
  logic [N*RW-1:0]  req_read_reg, req_write_reg;
  logic [N*DW-1:0]  req_write_value;
  logic [N-1:0]     busy, rd_valid, wr_ack, req_err;
  logic [DW-1:0]    rd_data, rf_read_value, rf_write_value;
  logic             rf_read_en, rf_write_en;
  logic [RW-1:0]    rf_read_reg, rf_write_reg;

  logic [DW-1:0]    mem [16];
  int checks = 0, failures = 0;
  int wr_pulses = 0, rd_pulses = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.NUM_CLIENTS(N), .REG_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_read_en(req_read_en), .req_read_reg(req_read_reg),
    .req_write_en(req_write_en), .req_write_reg(req_write_reg),
    .req_write_value(req_write_value),
    .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_ack(wr_ack), .req_err(req_err),
    .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_value(rf_read_value),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_value(rf_write_value)
  );

  // Register file: synchronous write, registered read output.
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_write_reg] <= rf_write_value;
    if (rf_read_en)  rf_read_value <= mem[rf_read_reg];
  end

  always @(negedge clk) begin
    if (rf_write_en) wr_pulses++;
    if (rf_read_en)  rd_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_req();
    req_read_en  = '0;
    req_write_en = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr_req();
  endtask

  task automatic drv_wr(input int c, input logic [RW-1:0] r, input logic [DW-1:0] v);
    req_write_en[c]           = 1'b1;
    req_write_reg[c*RW +: RW] = r;
    req_write_value[c*DW +: DW] = v;
  endtask

  task automatic drv_rd(input int c, input logic [RW-1:0] r);
    req_read_en[c]           = 1'b1;
    req_read_reg[c*RW +: RW] = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int wp0, rp0, ng, err_seen;
    int sent [N];
    int gnt [8];
    logic [RW-1:0] pc_r, lr_r;
    pc_r = RW'(REG_PC);
    lr_r = RW'(REG_LR);
    rst = 1'b1;
    clr_req();
    req_read_reg = '0; req_write_reg = '0; req_write_value = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp", {rd_valid, wr_ack, req_err}, 0);
    chk("rst_rf_en", {rf_read_en, rf_write_en}, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    nxt();

    // Single write, 3-cycle ack latency
    wp0 = wr_pulses;
    drv_wr(0, 4'd3, 32'hDEADBEEF);
    nxt(); chk("w_busy", busy, 2'b01); chk("w_en_early", rf_write_en, 0);
    nxt(); chk("w_en", rf_write_en, 1); chk("w_reg", rf_write_reg, 3);
           chk("w_val", rf_write_value, 32'hDEADBEEF); chk("w_ack_early", wr_ack, 0);
    nxt(); chk("w_ack", wr_ack, 2'b01); chk("w_busy_ack", busy, 2'b01); chk("w_en_off", rf_write_en, 0);
    nxt(); chk("w_ack_off", wr_ack, 0); chk("w_busy_off", busy, 0);
    chk("w_pulses", wr_pulses - wp0, 1);

    // Preload PC then read it from client 1, 5-cycle latency
    drv_wr(0, pc_r, 32'h1000);
    repeat (4) nxt();
    rp0 = rd_pulses;
    drv_rd(1, pc_r);
    nxt();
    nxt(); chk("r_en", rf_read_en, 1); chk("r_reg", rf_read_reg, 15);
    nxt(); chk("r_en_off", rf_read_en, 0);
    nxt(); chk("r_valid_early", rd_valid, 0);
    nxt(); chk("r_valid", rd_valid, 2'b10); chk("r_data", rd_data, 32'h1000);
    nxt(); chk("r_valid_off", rd_valid, 0); chk("r_busy_off", busy, 0);
    chk("r_pulses", rd_pulses - rp0, 1);
    repeat (2) nxt();
    chk("r_data_hold", rd_data, 32'h1000);

    // Collision: write LR from client 0, read LR from client 1
    drv_wr(0, lr_r, 32'h2004);
    drv_rd(1, lr_r);
    nxt(); chk("c_busy", busy, 2'b11);
    nxt(); chk("c_wr_en", rf_write_en, 1); chk("c_wr_reg", rf_write_reg, 14);
    nxt(); chk("c_ack", wr_ack, 2'b01);
    nxt(); chk("c_rd_en", rf_read_en, 1); chk("c_rd_reg", rf_read_reg, 14);
    nxt(); nxt();
    nxt(); chk("c_valid", rd_valid, 2'b10); chk("c_data", rd_data, 32'h2004);
    nxt();

    // Fairness: both clients keep re-requesting writes
    ng = 0; err_seen = 0;
    for (int c = 0; c < N; c++) sent[c] = 0;
    for (int cyc = 0; cyc < 80 && ng < 8; cyc++) begin
      nxt();
      if (req_err != 0) err_seen++;
      if (rf_write_en) begin
        gnt[ng] = int'(rf_write_value[31:28]);
        ng++;
      end
      for (int c = 0; c < N; c++)
        if (!busy[c] && sent[c] < 4) begin
          drv_wr(c, RW'(c + 1), {4'(c), 28'(sent[c])});
          sent[c]++;
        end
    end
    chk("f_grants", ng, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("f_gnt%0d", k), gnt[k], k % 2);
    chk("f_no_err", err_seen, 0);
    repeat (6) nxt();

    // Overrun while busy, then reissue in completion cycle
    wp0 = wr_pulses; rp0 = rd_pulses;
    drv_wr(0, 4'd5, 32'h55);
    nxt(); drv_rd(0, 4'd5);
    nxt(); chk("o_err", req_err, 2'b01); chk("o_wr_en", rf_write_en, 1); chk("o_wr_val", rf_write_value, 32'h55);
    nxt(); chk("o_err_off", req_err, 0); chk("o_ack", wr_ack, 2'b01);
           drv_wr(0, 4'd7, 32'h77);
    nxt(); chk("o_done_err", req_err, 2'b01); chk("o_busy_off", busy, 0);
    repeat (4) nxt();
    chk("o_wr_pulses", wr_pulses - wp0, 1); chk("o_rd_pulses", rd_pulses - rp0, 0);

    // Read and write from one client in the same cycle
    wp0 = wr_pulses; rp0 = rd_pulses;
    drv_rd(0, 4'd5); drv_wr(0, 4'd6, 32'h66);
    nxt(); chk("i_err", req_err, 2'b01); chk("i_busy", busy, 2'b01);
    nxt(); chk("i_wr_en", rf_write_en, 1); chk("i_wr_reg", rf_write_reg, 6); chk("i_wr_val", rf_write_value, 32'h66);
    nxt(); chk("i_ack", wr_ack, 2'b01);
    repeat (4) nxt();
    chk("i_wr_pulses", wr_pulses - wp0, 1); chk("i_rd_pulses", rd_pulses - rp0, 0);

    // Reset during RD_WAIT, then a fresh read of PC
    drv_rd(1, pc_r);
    nxt(); nxt(); nxt();
    rst = 1'b1;
    #1;
    chk("x_rf_en", {rf_read_en, rf_write_en}, 0);
    chk("x_busy", busy, 0);
    chk("x_valid", rd_valid, 0);
    nxt();
    rst = 1'b0;
    nxt();
    drv_rd(1, pc_r);
    repeat (5) nxt();
    chk("x_rd_valid", rd_valid, 2'b10);
    chk("x_rd_data", rd_data, 32'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
